cordic_range_wrap: RTL and testbench

- Angle-conditioning shell placed directly around cordic_iter. cordic_iter converges only for |angle| <= pi/2.
- Input side: accepts any signed Q4.20 angle in [-8, 8) over a valid/ready handshake.
- Range reduction: reduces the angle to [-pi, pi), then folds it into [-pi/2, pi/2].
- CORDIC side: drives the folded angle to cordic_iter with a data_loaded pulse and waits for data_computed.
- Output side: applies quadrant correction to the returned x/y and presents sin/cos downstream over a valid/ready handshake.

---
 rtl/cordic_pkg.sv | 8 +
 rtl/cordic_quadrant_fold.sv | 17 +
 rtl/cordic_range_wrap.sv | 141 ++++++++++++++
 tb/tb_cordic_range_wrap.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q4.20 angle constants and controller states for cordic_range_wrap.
package cordic_pkg;
    localparam int FRAC = 20;
    localparam logic [23:0] PI      = 24'h3243F7;
    localparam logic [23:0] HALF_PI = 24'h1921FB;
    localparam logic [23:0] TWO_PI  = 24'h6487ED;
    typedef enum logic [2:0] {IDLE, REDUCE, FOLD, LOAD, WAIT, OUT} state_e;
endpackage

// File: rtl/cordic_quadrant_fold.sv
// cordic_quadrant_fold: mirrors an angle in [-pi, pi) into [-pi/2, pi/2] and flags
// the cosine negation the mirror implies.
module cordic_quadrant_fold import cordic_pkg::*; #(
    parameter int WIDTH = 24
) (
    input  logic signed [WIDTH-1:0] acc_i,
    output logic signed [WIDTH-1:0] angle_o,
    output logic                    neg_o
);
    localparam logic signed [WIDTH-1:0] PI_W = WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] HP_W = WIDTH'(HALF_PI);
    logic hi, lo;
    assign hi      = acc_i > HP_W;
    assign lo      = acc_i < -HP_W;
    assign neg_o   = hi || lo;
    assign angle_o = hi ? PI_W - acc_i : lo ? -PI_W - acc_i : acc_i;
endmodule

// File: rtl/cordic_range_wrap.sv
// cordic_range_wrap: range-reduces and folds angles for cordic_iter, then quadrant-corrects its result.
// Optional watchdog with out_err port: define CORDIC_TIMEOUT_EN.
module cordic_range_wrap import cordic_pkg::*; #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_angle,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] cordic_angle,
    output logic             cordic_load,
    input  logic [WIDTH-1:0] cordic_x,
    input  logic [WIDTH-1:0] cordic_y,
    input  logic             cordic_done,
    output logic [WIDTH-1:0] out_sin,
    output logic [WIDTH-1:0] out_cos,
`ifdef CORDIC_TIMEOUT_EN
    output logic             out_err,
`endif
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic signed [WIDTH-1:0] PI_W     = WIDTH'(PI);
    localparam logic signed [WIDTH:0]   TWO_PI_X = (WIDTH+1)'(TWO_PI);

    state_e state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d, fold_angle;
    logic [WIDTH-1:0] angle_q, angle_d, sin_q, sin_d, cos_q, cos_d;
    logic neg_q, neg_d, fold_neg, done_prev_q, done_edge;
    logic signed [WIDTH:0] acc_x, sub_x, add_x;

    cordic_quadrant_fold #(.WIDTH(WIDTH)) u_fold (
        .acc_i   (acc_q),
        .angle_o (fold_angle),
        .neg_o   (fold_neg)
    );

    // One guard bit keeps the +/- 2*pi correction from wrapping near +/-8.
    assign acc_x     = {acc_q[WIDTH-1], acc_q};
    assign sub_x     = acc_x - TWO_PI_X;
    assign add_x     = acc_x + TWO_PI_X;
    assign done_edge = cordic_done && !done_prev_q;

    assign in_ready     = state_q == IDLE;
    assign cordic_load  = state_q == LOAD;
    assign out_valid    = state_q == OUT;
    assign cordic_angle = angle_q;
    assign out_sin      = sin_q;
    assign out_cos      = cos_q;

`ifdef CORDIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d, expired;
    assign expired = cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d   = state_q == WAIT ? cnt_q + 1'b1 : '0;
    assign out_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT > 0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        angle_d = angle_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
`ifdef CORDIC_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                acc_d   = in_angle;
                state_d = REDUCE;
`ifdef CORDIC_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            REDUCE: begin
                acc_d   = acc_q >= PI_W ? sub_x[WIDTH-1:0] : acc_q < -PI_W ? add_x[WIDTH-1:0] : acc_q;
                state_d = acc_q >= PI_W || acc_q < -PI_W ? REDUCE : FOLD;
            end
            FOLD: begin
                acc_d   = fold_angle;
                angle_d = fold_angle;
                neg_d   = fold_neg;
                state_d = LOAD;
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if (done_edge) begin
                    sin_d   = cordic_y;
                    cos_d   = neg_q ? -cordic_x : cordic_x;
                    state_d = OUT;
                end
`ifdef CORDIC_TIMEOUT_EN
                else if (expired) begin
                    sin_d   = '0;
                    cos_d   = '0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end
`endif
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            angle_q     <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            done_prev_q <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            angle_q     <= angle_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            done_prev_q <= cordic_done;
`ifdef CORDIC_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_cordic_range_wrap.sv
// tb_cordic_range_wrap: random angles through cordic_range_wrap with an ideal cordic_iter
// stand-in; results checked against real-valued sin/cos and an integer reduction model.
module tb_cordic_range_wrap;
    localparam int W  = 24;
    localparam int PI = 32'h3243F7;
    localparam int HP = 32'h1921FB;
    localparam int TP = 32'h6487ED;
    localparam real SC = 1048576.0;

    logic clk = 0, rst = 0;
    logic [W-1:0] in_angle = '0, cordic_x = '0, cordic_y = '0;
    logic in_valid = 0, cordic_done = 0, out_ready = 0;
    logic in_ready, cordic_load, out_valid;
    logic [W-1:0] cordic_angle, out_sin, out_cos;
`ifdef CORDIC_TIMEOUT_EN
    logic out_err;
`endif

    int total = 0, bad = 0;
    int q_ang[$];
    bit no_resp = 0, hold_stall = 0, expect_err = 0;

    always #5 clk = ~clk;

    cordic_range_wrap dut (
        .clk(clk), .rst(rst), .in_angle(in_angle), .in_valid(in_valid), .in_ready(in_ready),
        .cordic_angle(cordic_angle), .cordic_load(cordic_load), .cordic_x(cordic_x),
        .cordic_y(cordic_y), .cordic_done(cordic_done), .out_sin(out_sin), .out_cos(out_cos),
`ifdef CORDIC_TIMEOUT_EN
        .out_err(out_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        total++;
        if (act - exp > tol || exp - act > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Wrap into [-pi, pi) by whole turns, then mirror about +/-pi/2.
    function automatic int ref_fold(input int a, output bit neg);
        int r;
        r = a;
        while (r >= PI) r -= TP;
        while (r < -PI) r += TP;
        neg = r > HP || r < -HP;
        return r > HP ? PI - r : r < -HP ? -PI - r : r;
    endfunction

    function automatic bit lit(input int a, output int e);
        e = 0;
        case (a)
            32'h200000:  e = 32'h1243F7;
            32'h700000:  e = 32'h0B7813;
            -8388608:    e = -1493988;
            32'h3243F7:  e = -1;
            default:     return 0;
        endcase
        return 1;
    endfunction

    // Ideal cordic_iter: junk on x/y until a fresh done rising edge, sometimes leaves done high.
    initial begin
        real r;
        forever begin
            @(negedge clk);
            if (cordic_load && !no_resp && rst) begin
                r = $itor($signed(cordic_angle)) / SC;
                cordic_x = W'($urandom);
                cordic_y = W'($urandom);
                repeat ($urandom_range(1, 5)) @(negedge clk);
                if (cordic_done) begin
                    cordic_done = 0;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
                cordic_x = W'($rtoi($cos(r) * SC));
                cordic_y = W'($rtoi($sin(r) * SC));
                cordic_done = 1;
                if ($urandom_range(0, 2) != 0) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    cordic_done = 0;
                end
            end
        end
    end

    initial begin
        bit was_valid, hs, n;
        logic [W-1:0] ps, pc;
        int e, cx;
        real r;
        was_valid = 0; hs = 0; ps = '0; pc = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                was_valid = 0; hs = 0; out_ready = 0;
                continue;
            end
            if (hs) begin
                chk("in_ready after handshake", in_ready, 1);
                chk("out_valid after handshake", out_valid, 0);
            end
            if (cordic_load) begin
                chk("inputs pending at load", q_ang.size(), 1);
                e = ref_fold(q_ang[0], n);
                chk("cordic_angle", $signed(cordic_angle), e);
                if (lit(q_ang[0], e)) chk("cordic_angle literal", $signed(cordic_angle), e);
                chk("in_ready while busy", in_ready, 0);
            end
            if (out_valid) begin
                if (was_valid && !out_ready) begin
                    chk("held out_sin", out_sin, ps);
                    chk("held out_cos", out_cos, pc);
                    chk("in_ready during stall", in_ready, 0);
                end else if (expect_err) begin
`ifdef CORDIC_TIMEOUT_EN
                    chk("out_err on timeout", out_err, 1);
`endif
                    chk("timeout out_sin", out_sin, 0);
                    chk("timeout out_cos", out_cos, 0);
                end else begin
                    r = $itor(q_ang[0]) / SC;
                    void'(ref_fold(q_ang[0], n));
                    cx = $signed(cordic_x);
                    chk("out_sin exact", $signed(out_sin), $signed(cordic_y));
                    chk("out_cos exact", $signed(out_cos), n ? -cx : cx);
                    chk_near("sin vs real", $signed(out_sin), $rtoi($sin(r) * SC), 16);
                    chk_near("cos vs real", $signed(out_cos), $rtoi($cos(r) * SC), 16);
`ifdef CORDIC_TIMEOUT_EN
                    chk("out_err clear", out_err, 0);
`endif
                end
                ps = out_sin; pc = out_cos;
            end
            out_ready = hold_stall ? 1'b0 : $urandom_range(0, 3) != 0;
            hs = out_valid && out_ready;
            if (hs) void'(q_ang.pop_front());
            was_valid = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a);
        for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("wait in_ready", in_ready, 1);
        in_angle = a;
        in_valid = 1;
        q_ang.push_back($signed(a));
        @(negedge clk);
        in_valid = 0;
        in_angle = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (q_ang.size() != 0 || !in_ready); i++) @(negedge clk);
        chk("drained", q_ang.size(), 0);
    endtask

    initial begin
        logic [W-1:0] dir[9];
        dir = '{24'h200000, 24'h700000, 24'h800000, 24'h3243F7, 24'hCDBC09,
                24'h3243F6, 24'h1921FB, 24'h7FFFFF, 24'h000000};
        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset cordic_load", cordic_load, 0);
        chk("reset cordic_angle", cordic_angle, 0);
        chk("reset out_sin", out_sin, 0);
        chk("reset out_cos", out_cos, 0);
        rst = 1;
        @(negedge clk);
        foreach (dir[i]) send(dir[i]);
        for (int i = 0; i < 40; i++) send(W'($urandom));
        wait_idle();

        hold_stall = 1;
        send(24'h200000);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        chk("stall reaches out_valid", out_valid, 1);
        repeat (10) @(negedge clk);
        hold_stall = 0;
        wait_idle();

        cordic_done = 0;
        no_resp = 1;
        send(24'h600000);
        for (int i = 0; i < 50 && !cordic_load; i++) @(negedge clk);
        chk("load before abort", cordic_load, 1);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        q_ang.delete();
        cordic_done = 1;
        repeat (2) @(negedge clk);
        cordic_done = 0;
        no_resp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no out_valid after abort", out_valid, 0);
            chk("in_ready after abort", in_ready, 1);
        end

`ifdef CORDIC_TIMEOUT_EN
        no_resp = 1;
        expect_err = 1;
        send(24'h100000);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        chk("timeout reaches out_valid", out_valid, 1);
        wait_idle();
        expect_err = 0;
        no_resp = 0;
`endif
        for (int i = 0; i < 10; i++) send(W'($urandom));
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
